pipe_register_chain: RTL and testbench

- Parametrised successor to the single-stage enable register.
- A chain of DEPTH data registers with valid/ready flow control, an optional skid slot per stage, a synchronous flush, and an occupancy count.
- Used between core pipeline stages and in memory/bus datapaths where backpressure must stall data without losing words.

---
 rtl/pipe_register_chain_pkg.sv | 17 +
 rtl/pipe_register_stage.sv | 79 +++++++
 rtl/pipe_register_chain.sv | 73 +++++++
 tb/tb_pipe_register_chain.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_register_chain_pkg.sv
// Shared constants and helpers for the pipelined register chain.
package pipe_register_chain_pkg;

  localparam logic VldEmpty = 1'b0;
  localparam logic VldFull  = 1'b1;

  // Bits needed to hold values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// One valid/ready register stage with an optional skid slot behind the main register.
module pipe_register_stage
  import pipe_register_chain_pkg::*;
#(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  INIT  = '0,
  parameter int unsigned       SKID  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o
);

  logic             v_q, v_d, sv_q, sv_d;
  logic [WIDTH-1:0] m_q, m_d, s_q, s_d;
  logic             accept, drain;

  // With a skid slot, ready depends only on local state, breaking the ready chain.
  assign up_ready_o = (SKID != 0) ? (sv_q == VldEmpty) : ((v_q == VldEmpty) || dn_ready_i);
  assign accept     = up_valid_i && up_ready_o;
  assign drain      = (v_q == VldFull) && dn_ready_i;
  assign dn_valid_o = v_q;
  assign dn_data_o  = m_q;

  always_comb begin
    v_d  = v_q;
    sv_d = sv_q;
    m_d  = m_q;
    s_d  = s_q;
    if (SKID == 0) begin
      if (accept) begin
        m_d = up_data_i;
        v_d = VldFull;
      end else if (drain) begin
        v_d = VldEmpty;
      end
    end else if ((v_q == VldEmpty) || drain) begin
      if (sv_q == VldFull) begin
        // Skid word moves up first so it never gets passed by a newer word.
        m_d  = s_q;
        v_d  = VldFull;
        sv_d = VldEmpty;
        if (accept) begin
          s_d  = up_data_i;
          sv_d = VldFull;
        end
      end else if (accept) begin
        m_d = up_data_i;
        v_d = VldFull;
      end else begin
        v_d = VldEmpty;
      end
    end else if (accept) begin
      s_d  = up_data_i;
      sv_d = VldFull;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      v_q  <= VldEmpty;
      sv_q <= VldEmpty;
      m_q  <= INIT;
      s_q  <= INIT;
    end else begin
      v_q  <= v_d;
      sv_q <= sv_d;
      m_q  <= m_d;
      s_q  <= s_d;
    end
  end

endmodule

// File: rtl/pipe_register_chain.sv
// Chain of DEPTH valid/ready register stages with flush and a registered occupancy count.
module pipe_register_chain
  import pipe_register_chain_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int unsigned      DEPTH = 2,
  parameter int unsigned      SKID  = 1,
  localparam int unsigned     CW    = clog2(DEPTH * (1 + SKID) + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH:0]   vld;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] dat [DEPTH+1];
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer, out_xfer;

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_register_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT),
      .SKID  (SKID)
    ) u_stage (
      .clk_i      (clock),
      .rst_i      (reset),
      .flush_i    (flush),
      .up_valid_i (vld[k]),
      .up_ready_o (rdy[k]),
      .up_data_i  (dat[k]),
      .dn_valid_o (vld[k+1]),
      .dn_ready_i (rdy[k+1]),
      .dn_data_o  (dat[k+1])
    );
  end

  // Skid chains advertise not-ready while held in reset.
  assign in_ready  = rdy[0] && !((SKID != 0) && reset);
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (in_xfer && !out_xfer) count_d = count_q + CW'(1);
    if (out_xfer && !in_xfer) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_register_chain.sv
// Scoreboard bench: a skid chain (DEPTH=2) and a no-skid chain (DEPTH=3) share one stimulus stream.
module tb_pipe_register_chain;

  localparam logic [31:0] Init = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [2:0]  a_count;
  logic [1:0]  b_count;

  always #5 clock = ~clock;

  pipe_register_chain #(.WIDTH(32), .INIT(Init), .DEPTH(2), .SKID(1)) u_dut_a (
    .clock (clock), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (a_in_ready), .in_data (in_data),
    .out_valid (a_out_valid), .out_ready (out_ready), .out_data (a_out_data),
    .count (a_count)
  );

  pipe_register_chain #(.WIDTH(32), .INIT(Init), .DEPTH(3), .SKID(0)) u_dut_b (
    .clock (clock), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (b_in_ready), .in_data (in_data),
    .out_valid (b_out_valid), .out_ready (out_ready), .out_data (b_out_data),
    .count (b_count)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [31:0] sq   [2][$];
  bit          hold [2];
  logic [31:0] held [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: a FIFO of words held by the chain, bounded by capacity.
  task automatic mon(input int id, input logic ir, input logic ov, input logic [31:0] od,
                     input int cnt, input int cap);
    int sz;
    sz = sq[id].size();
    chk($sformatf("count[%0d]", id), cnt, sz);
    if (hold[id]) begin
      chk($sformatf("ov_stable[%0d]", id), {31'd0, ov}, 32'd1);
      chk($sformatf("od_stable[%0d]", id), od, held[id]);
    end
    if (ov === 1'b1) begin
      if (sz == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_word[%0d]: got %h, expected no word", id, od);
      end else begin
        chk($sformatf("out_data[%0d]", id), od, sq[id][0]);
      end
    end
    if (sz == cap) begin
      chk($sformatf("full_ready[%0d]", id), {31'd0, ir}, (id == 1) ? {31'd0, out_ready} : 32'd0);
    end
    if (ov === 1'b1 && out_ready) void'(sq[id].pop_front());
    if (in_valid && ir === 1'b1) sq[id].push_back(in_data);
    if (reset || flush) sq[id].delete();
    hold[id] = (ov === 1'b1) && !out_ready && !reset && !flush;
    held[id] = od;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon(0, a_in_ready, a_out_valid, a_out_data, int'(a_count), 4);
      mon(1, b_in_ready, b_out_valid, b_out_data, int'(b_count), 3);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic        a_ov [8];
  logic        b_ov [8];
  logic [31:0] a_od [8];
  logic [31:0] b_od [8];
  int          a_cnt_max, k, seen;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    chk("rst_a_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_out_data", a_out_data, Init);
    chk("rst_a_count", {29'd0, a_count}, 32'd0);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    chk("rst_b_out_data", b_out_data, Init);
    chk("rst_b_count", {30'd0, b_count}, 32'd0);
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    tick();

    // Stream three words into empty chains.
    out_ready = 1'b1;
    a_cnt_max = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 3);
      in_data  = 32'(i + 1);
      @(negedge clock);
      a_ov[i] = a_out_valid; a_od[i] = a_out_data;
      b_ov[i] = b_out_valid; b_od[i] = b_out_data;
      if (int'(a_count) > a_cnt_max) a_cnt_max = int'(a_count);
      tick();
    end
    chk("lat_a_c1", {31'd0, a_ov[1]}, 32'd0);
    chk("lat_a_c2", {31'd0, a_ov[2]}, 32'd1);
    chk("str_a_w1", a_od[2], 32'd1);
    chk("str_a_w2", a_od[3], 32'd2);
    chk("str_a_w3", a_od[4], 32'd3);
    chk("str_a_c5", {31'd0, a_ov[5]}, 32'd0);
    chk("str_a_peak", a_cnt_max, 32'd2);
    chk("lat_b_c2", {31'd0, b_ov[2]}, 32'd0);
    chk("lat_b_c3", {31'd0, b_ov[3]}, 32'd1);
    chk("str_b_w3", b_od[5], 32'd3);

    // Backpressure fill.
    in_valid = 1'b0; out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (k < 6);
      in_data  = 32'hA0 + 32'(k);
      @(negedge clock);
      if (a_in_ready && in_valid) k++;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_accepted", k, 32'd4);
    chk("bp_a_count", {29'd0, a_count}, 32'd4);
    chk("bp_a_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("bp_a_head", a_out_data, 32'hA0);
    chk("bp_b_count", {30'd0, b_count}, 32'd3);
    chk("bp_b_in_ready", {31'd0, b_in_ready}, 32'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) begin
        chk("skid_no_comb_ready", {31'd0, a_in_ready}, 32'd0);
        chk("noskid_comb_ready", {31'd0, b_in_ready}, 32'd1);
      end
      chk("drain_a_order", a_out_data, 32'hA0 + 32'(i));
      tick();
    end
    @(negedge clock);
    chk("drain_a_count", {29'd0, a_count}, 32'd0);
    chk("drain_b_count", {30'd0, b_count}, 32'd0);
    tick();

    // Flush with three words held and an offered word.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("fl_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("fl_a_count", {29'd0, a_count}, 32'd0);
    chk("fl_a_out_data", a_out_data, Init);
    chk("fl_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    chk("fl_b_count", {30'd0, b_count}, 32'd0);
    tick();
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (a_out_valid || b_out_valid) seen++;
      tick();
    end
    chk("fl_no_words", seen, 32'd0);

    // Fill, then run simultaneous in/out from full.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i);
      tick();
    end
    @(negedge clock);
    chk("full_a_count", {29'd0, a_count}, 32'd4);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    @(negedge clock);
    chk("sim_a_empty", sq[0].size(), 32'd0);
    chk("sim_b_empty", sq[1].size(), 32'd0);
    tick();

    // Random valid/ready with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    @(negedge clock);
    chk("rnd_drain_a", sq[0].size(), 32'd0);
    chk("rnd_drain_b", sq[1].size(), 32'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    chk("rst2_a_out_data", a_out_data, Init);
    chk("rst2_b_out_data", b_out_data, Init);
    chk("rst2_a_out_valid", {31'd0, a_out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
